// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - run/stop phase sequencer emitting one-hot strobes for the 5-phase datapath
// Defining PHASE_SEQ_STEP_EN adds the single-step STEP state driven by the step button.
module phase_sequencer #(
  parameter int NPHASE = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              exec,
  input  logic              step,
  input  logic              halt_req,
  input  logic              stall,
  output logic [2:0]        phase,
  output logic [NPHASE-1:0] phase_bus,
  output logic              running,
  output logic              reset_ps,
  output logic [CNT_W-1:0]  icount
);

`ifdef PHASE_SEQ_STEP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STEP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

  localparam logic [2:0]        LAST_PHASE = 3'(NPHASE - 1);
  localparam logic [NPHASE-1:0] FIRST_BUS  = NPHASE'(1);

  state_t             state, state_n;
  logic [2:0]         phase_n;
  logic [NPHASE-1:0]  bus_n;
  logic [CNT_W-1:0]   icount_n;
  logic               stop_pend, stop_n;
  logic               halt_flag, halt_n;
  logic               exec_q, step_q;
  logic [1:0]         rst_sync;
  logic               exec_rise;
  logic               single;
  logic               end_stop;

  // Button edges are masked until the datapath reset has been released.
  assign exec_rise = exec & ~exec_q & ~reset_ps;
  assign reset_ps  = rst_sync[1];
  assign running   = (state != IDLE);

`ifdef PHASE_SEQ_STEP_EN
  logic step_rise;
  assign step_rise = step & ~step_q & ~reset_ps;
  assign single    = (state == STEP);
`else
  logic unused_step;
  assign unused_step = step_q;
  assign single      = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      phase     <= 3'd0;
      phase_bus <= '0;
      stop_pend <= 1'b0;
      halt_flag <= 1'b0;
      icount    <= '0;
      exec_q    <= 1'b0;
      step_q    <= 1'b0;
      rst_sync  <= 2'b11;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      phase_bus <= bus_n;
      stop_pend <= stop_n;
      halt_flag <= halt_n;
      icount    <= icount_n;
      exec_q    <= exec;
      step_q    <= step;
      rst_sync  <= {rst_sync[0], 1'b0};
    end
  end

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    bus_n    = phase_bus;
    stop_n   = stop_pend;
    halt_n   = halt_flag;
    icount_n = icount;
    end_stop = 1'b0;
    case (state)
      IDLE: begin
        if (exec_rise) begin
          state_n = RUN;
          phase_n = 3'd0;
          bus_n   = FIRST_BUS;
        end
`ifdef PHASE_SEQ_STEP_EN
        else if (step_rise) begin
          state_n = STEP;
          phase_n = 3'd0;
          bus_n   = FIRST_BUS;
        end
`endif
      end
      default: begin
        // Events arriving in the final phase still apply to the instruction in flight.
        if (halt_req)
          halt_n = 1'b1;
        if (exec_rise && !single)
          stop_n = 1'b1;
        if (!stall) begin
          if (phase == LAST_PHASE) begin
            icount_n = icount + 1'b1;
            phase_n  = 3'd0;
            end_stop = stop_n | halt_n | single;
            if (end_stop) begin
              state_n = IDLE;
              bus_n   = '0;
              stop_n  = 1'b0;
              halt_n  = 1'b0;
            end else begin
              bus_n = FIRST_BUS;
            end
          end else begin
            phase_n = phase + 3'd1;
            bus_n   = FIRST_BUS << phase_n;
          end
        end
      end
    endcase
  end

endmodule
